// File: rtl/gerenciador_bolas_inimigas.sv
// -----------------------------------------------------------------------------
// gerenciador_bolas_inimigas
// Manages a pool of N_BOLAS falling enemy balls. Balls spawn at pseudo-random
// x positions on the top edge, fall VEL pixels per movement tick, cost a life
// when they overlap the ship and score a dodge point when they leave the
// bottom of the screen. One movement tick triggers a sweep: one cycle per slot
// (collision/move), followed by one spawn cycle.
//
// Ports:
//   CLOCK_50      in   system clock, rising edge
//   reset         in   synchronous active-high reset, clears all state
//   pausa         in   1 = freeze the movement tick counter
//   x_nave        in   ship left x
//   y_nave        in   ship top y
//   largura_nave  in   ship width
//   altura_nave   in   ship height
//   x_bolas       out  ball center x, slot i in bits [10i+9:10i]
//   y_bolas       out  ball center y, same packing
//   ativas        out  bit i = slot i is live
//   raio_bolas    out  constant ball radius
//   acerto        out  one-cycle pulse per ship hit
//   vidas         out  remaining lives
//   pontos        out  dodged-ball count (saturating)
//   fim_jogo      out  sticky game-over flag
// -----------------------------------------------------------------------------
module gerenciador_bolas_inimigas #(
  parameter int N_BOLAS      = 4,
  parameter int TICK_DIV     = 833333,
  parameter int VEL          = 2,
  parameter int RAIO         = 5,
  parameter int LARGURA_TELA = 640,
  parameter int ALTURA_TELA  = 480,
  parameter int SPAWN_TICKS  = 60,
  parameter int VIDAS_INI    = 3
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   pausa,
  input  logic [9:0]             x_nave,
  input  logic [9:0]             y_nave,
  input  logic [9:0]             largura_nave,
  input  logic [9:0]             altura_nave,
  output logic [10*N_BOLAS-1:0]  x_bolas,
  output logic [10*N_BOLAS-1:0]  y_bolas,
  output logic [N_BOLAS-1:0]     ativas,
  output logic [9:0]             raio_bolas,
  output logic                   acerto,
  output logic [3:0]             vidas,
  output logic [9:0]             pontos,
  output logic                   fim_jogo
);

  localparam int IW = (N_BOLAS > 1) ? $clog2(N_BOLAS) : 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    VARRE  = 2'd1,
    SPAWN  = 2'd2
  } estado_t;

  estado_t             r_estado;
  estado_t             w_prox;
  logic [9:0]          r_lfsr;
  logic [TW-1:0]       r_tick_cnt;
  logic [SW-1:0]       r_spawn_cnt;
  logic [IW-1:0]       r_idx;
  logic [9:0]          r_x [N_BOLAS];
  logic [9:0]          r_y [N_BOLAS];
  logic [N_BOLAS-1:0]  r_ativas;
  logic                r_acerto;
  logic [3:0]          r_vidas;
  logic [9:0]          r_pontos;
  logic                r_fim_jogo;

  logic                w_conta;
  logic                w_tick;
  logic                w_ultimo;
  logic [10:0]         w_x_cur;
  logic [10:0]         w_y_cur;
  logic [10:0]         w_y_prox;
  logic                w_hit_x;
  logic                w_hit_y;
  logic                w_colide;
  logic                w_hit;
  logic                w_sai;
  logic                w_fim_agora;
  logic [10:0]         w_x_soma;
  logic [9:0]          w_x_spawn;
  logic                w_livre_ok;
  logic [IW-1:0]       w_livre_idx;

  // The tick counter only runs while the game is live and not paused.
  assign w_conta  = ~pausa & ~r_fim_jogo;
  assign w_tick   = w_conta & (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_ultimo = (r_idx == IW'(N_BOLAS - 1));

  // Collision and movement use the pre-move position in 11-bit arithmetic.
  assign w_x_cur  = {1'b0, r_x[r_idx]};
  assign w_y_cur  = {1'b0, r_y[r_idx]};
  assign w_y_prox = w_y_cur + 11'(VEL);
  assign w_hit_x  = (w_x_cur + 11'(RAIO) > {1'b0, x_nave}) &&
                    (w_x_cur < {1'b0, x_nave} + {1'b0, largura_nave} + 11'(RAIO));
  assign w_hit_y  = (w_y_cur + 11'(RAIO) > {1'b0, y_nave}) &&
                    (w_y_cur < {1'b0, y_nave} + {1'b0, altura_nave} + 11'(RAIO));
  assign w_colide = w_hit_x & w_hit_y;
  assign w_hit    = (r_estado == VARRE) & r_ativas[r_idx] & w_colide;
  assign w_sai    = (w_y_prox >= 11'(ALTURA_TELA + RAIO));

  // The game ends on this cycle if the last life is lost by the current hit.
  assign w_fim_agora = r_fim_jogo | (w_hit & (r_vidas == 4'd1));

  // Spawn x; the clamp only matters if the screen is misconfigured narrower
  // than the 9-bit random span.
  assign w_x_soma  = 11'(RAIO) + {2'b00, r_lfsr[8:0]};
  assign w_x_spawn = (w_x_soma > 11'(LARGURA_TELA - 1)) ? 10'(LARGURA_TELA - 1) : w_x_soma[9:0];

  // Lowest-index free slot: scan downwards so the smallest index wins.
  always_comb begin
    w_livre_ok  = 1'b0;
    w_livre_idx = '0;
    for (int i = N_BOLAS - 1; i >= 0; i--) begin
      w_livre_ok  = w_livre_ok | ~r_ativas[i];
      w_livre_idx = r_ativas[i] ? w_livre_idx : IW'(i);
    end
  end

  // Next-state logic for the tick / sweep / spawn sequence.
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO: begin
        if (w_tick) begin
          w_prox = VARRE;
        end else begin
          w_prox = OCIOSO;
        end
      end
      VARRE: begin
        if (w_ultimo) begin
          w_prox = w_fim_agora ? OCIOSO : SPAWN;
        end else begin
          w_prox = VARRE;
        end
      end
      SPAWN:   w_prox = OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox;
    end
  end

  // Game datapath: LFSR, tick/spawn counters, slot array, score and lives.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_lfsr      <= 10'h2A5;
      r_tick_cnt  <= '0;
      r_spawn_cnt <= '0;
      r_idx       <= '0;
      r_ativas    <= '0;
      r_acerto    <= 1'b0;
      r_vidas     <= 4'(VIDAS_INI);
      r_pontos    <= 10'd0;
      r_fim_jogo  <= 1'b0;
      for (int i = 0; i < N_BOLAS; i++) begin
        r_x[i] <= 10'd0;
        r_y[i] <= 10'd0;
      end
    end else begin
      // x^10 + x^7 + 1, free-running even when paused or after game over.
      r_lfsr   <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
      r_acerto <= 1'b0;

      if (w_conta) begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      end

      case (r_estado)
        OCIOSO: begin
          r_idx <= '0;
        end
        VARRE: begin
          if (r_ativas[r_idx]) begin
            if (w_colide) begin
              r_ativas[r_idx] <= 1'b0;
              r_acerto        <= 1'b1;
              if (r_vidas != 4'd0) begin
                r_vidas <= r_vidas - 4'd1;
              end
              if (r_vidas == 4'd1) begin
                r_fim_jogo <= 1'b1;
              end
            end else if (w_sai) begin
              r_ativas[r_idx] <= 1'b0;
              if (r_pontos != 10'h3FF) begin
                r_pontos <= r_pontos + 10'd1;
              end
            end else begin
              r_y[r_idx] <= w_y_prox[9:0];
            end
          end
          r_idx <= r_idx + IW'(1);
        end
        SPAWN: begin
          if (r_spawn_cnt == SW'(SPAWN_TICKS - 1)) begin
            // With no free slot the counter holds, so the attempt repeats.
            if (w_livre_ok) begin
              r_x[w_livre_idx]      <= w_x_spawn;
              r_y[w_livre_idx]      <= 10'(RAIO);
              r_ativas[w_livre_idx] <= 1'b1;
              r_spawn_cnt           <= '0;
            end
          end else begin
            r_spawn_cnt <= r_spawn_cnt + SW'(1);
          end
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  // Pack slot registers onto the flat renderer buses.
  for (genvar g = 0; g < N_BOLAS; g++) begin : g_pack
    assign x_bolas[10*g +: 10] = r_x[g];
    assign y_bolas[10*g +: 10] = r_y[g];
  end

  assign ativas     = r_ativas;
  assign raio_bolas = 10'(RAIO);
  assign acerto     = r_acerto;
  assign vidas      = r_vidas;
  assign pontos     = r_pontos;
  assign fim_jogo   = r_fim_jogo;

endmodule

// File: doc/gerenciador_bolas_inimigas.md
Name: gerenciador_bolas_inimigas

Overview:
- Replaces the fixed, hard-wired enemy ball with a pool of N_BOLAS independently moving enemy balls.
- Balls spawn at pseudo-random x positions along the top edge and fall at constant speed.
- A ball that overlaps the ship costs a life; a ball that leaves the bottom of the screen scores a dodge point.
- Sits between the ship module (ship geometry in) and the memory/renderer (packed ball positions and active mask out).

Parameters:
- N_BOLAS, 4, number of ball slots (1..16).
- TICK_DIV, 833333, CLOCK_50 cycles per movement tick; must be > N_BOLAS+2.
- VEL, 2, pixels added to y per tick.
- RAIO, 5, ball radius in pixels; RAIO+511 < LARGURA_TELA.
- LARGURA_TELA, 640, screen width.
- ALTURA_TELA, 480, screen height.
- SPAWN_TICKS, 60, ticks between spawn attempts (>=1).
- VIDAS_INI, 3, lives after reset (1..15).

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- pausa  in  1  1 = freeze the tick counter.
- x_nave  in  10  ship left x.
- y_nave  in  10  ship top y.
- largura_nave  in  10  ship width.
- altura_nave  in  10  ship height.
- x_bolas  out  10*N_BOLAS  ball center x; slot i occupies bits [10i+9:10i].
- y_bolas  out  10*N_BOLAS  ball center y, same packing.
- ativas  out  N_BOLAS  bit i = slot i is live (renderer draws only live slots).
- raio_bolas  out  10  constant RAIO.
- acerto  out  1  one-cycle pulse per ship hit.
- vidas  out  4  remaining lives.
- pontos  out  10  dodged-ball count, saturates at 1023.
- fim_jogo  out  1  sticky game-over flag.

Behaviour:

Reset values (synchronous reset dominates every other input on that edge):
- ativas=0, x/y=0, acerto=0, vidas=VIDAS_INI, pontos=0, fim_jogo=0.
- FSM=OCIOSO, tick counter=0, spawn counter=0, slot index=0.
- LFSR=10'h2A5.

LFSR:
- 10-bit Fibonacci, polynomial x^10+x^7+1.
- Shifts every cycle, including during pausa and after fim_jogo.

Tick counter:
- Increments when pausa=0 and fim_jogo=0; holds otherwise.
- When it equals TICK_DIV-1 it wraps to 0 and asserts the internal tick for one cycle.
- First tick occurs TICK_DIV cycles after reset deasserts.

FSM states: OCIOSO, VARRE, SPAWN.
- OCIOSO: on tick, go to VARRE with i=0.
- VARRE: handles slot i in one cycle, then i++. After i=N_BOLAS-1, go to SPAWN.
  - Inactive slot: unchanged.
  - Active slot, collision test first, using the current (pre-move) position in 11-bit unsigned arithmetic:
    - Hit when all of: x+RAIO > x_nave, x < x_nave+largura_nave+RAIO, y+RAIO > y_nave, y < y_nave+altura_nave+RAIO.
    - On hit: clear ativas[i]; acerto=1 on the next cycle only; vidas decrements, saturating at 0.
    - If vidas becomes 0, set fim_jogo.
  - Active slot, no hit:
    - Compute y' = y+VEL in 11 bits.
    - If y' >= ALTURA_TELA+RAIO: clear ativas[i] and pontos++ (saturating). Otherwise y=y'.
- SPAWN: one cycle.
  - If spawn counter = SPAWN_TICKS-1, find the lowest-index inactive slot.
    - Slot found: set x = RAIO + LFSR[8:0], y = RAIO, set its active bit, clear spawn counter.
    - No slot free: hold the spawn counter, so the attempt repeats next tick.
  - Otherwise increment the spawn counter.
  - Then go to OCIOSO.

Timing and interaction rules:
- Sweep latency is N_BOLAS+1 cycles per tick. Outputs change only during VARRE and SPAWN.
- Multiple hits in one sweep give separate acerto pulses on consecutive cycles and one decrement each.
- pausa only gates ticks; a sweep already in progress completes.
- fim_jogo:
  - Asserted mid-sweep, the remaining slots are still processed (no further decrement once vidas=0) and SPAWN is skipped.
  - The FSM then stays in OCIOSO until reset.
  - Ball positions freeze and remain visible.
- Ship inputs are sampled live each VARRE cycle; no latching.

Test Plan:
(Setup: N_BOLAS=4, TICK_DIV=8, VEL=4, RAIO=5, SPAWN_TICKS=2, VIDAS_INI=3.)
1. Reset, ship at (0,400,50,10).
   - tick 1: no spawn.
   - tick 2: SPAWN sets ativas=0001, y0=5, 5 <= x0 <= 516.
   - tick 4: ativas=0011.
2. Ship far away, single ball at y=5.
   - y advances by 4 per tick.
   - After 120 sweeps y'=485 >= 485, so ativas[0] clears and pontos=1.
3. Ship at x_nave=x0-10, y_nave=200, size 50x10.
   - Ball reaches y=197, giving y+5 > 200.
   - Next sweep: acerto pulses 1 cycle, vidas 3->2, slot cleared.
4. Three hits across sweeps.
   - vidas=0, fim_jogo=1.
   - Tick counter and positions frozen for 1000 cycles; only reset restores vidas=3.
5. pausa=1 for 100 cycles between ticks: tick counter holds, no position change; pausa=0 resumes from the held count.
6. All 4 slots live at a spawn tick: spawn counter holds at 1. Next tick after a slot frees: spawn into the lowest free index. Reset asserted mid-VARRE: next cycle all outputs at reset values.
